// File: rtl/fsm_arb_pkg.sv
// Shared types and limits for the round-robin job arbiter.
package fsm_arb_pkg;

  localparam int ARB_NUM_REQ_MAX = 16;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    ISSUE = 4'b0010,
    WAIT  = 4'b0100,
    DONE  = 4'b1000
  } arb_state_t;

endpackage

// File: rtl/fsm_job_arbiter_if.sv
// Requester-side and engine-side signals of the job arbiter.
interface fsm_job_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] ack;
  logic               resp_err;
  logic               eng_start;
  logic               eng_done;
  logic               busy;
  logic               timeout_err;
  logic               err_clr;

  modport master (
    output req, eng_done, err_clr,
    input  gnt, ack, resp_err, eng_start, busy, timeout_err
  );

  modport slave (
    input  req, eng_done, err_clr,
    output gnt, ack, resp_err, eng_start, busy, timeout_err
  );
endinterface

// File: rtl/fsm_job_arbiter_rr_picker.sv
// Combinational round-robin search starting just after last_ptr.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx
);
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    idx      = '0;
    found    = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = IDX_W'((32'(last_ptr) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick_idx  = idx;
        pick[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fsm_job_arbiter.sv
// Shares one start/done engine among NUM_REQ requesters with a watchdog abort.
module fsm_job_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  fsm_job_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   last_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] ack;
  logic               resp_err;
  logic               eng_start;
  logic               busy;
  logic               timeout_err;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .pick     (pick),
    .pick_idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_ptr    <= IDX_W'(NUM_REQ - 1);
      gnt_idx     <= '0;
      gnt         <= '0;
      ack         <= '0;
      resp_err    <= 1'b0;
      eng_start   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      // Clear first so a timeout set later in this cycle takes priority.
      if (bus.err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state     <= ISSUE;
            gnt       <= pick;
            gnt_idx   <= pick_idx;
            eng_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ISSUE: begin
          state     <= WAIT;
          eng_start <= 1'b0;
          cnt       <= '0;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.eng_done) begin
            state <= DONE;
            ack   <= gnt;
          end else if (cnt == CNT_LAST) begin
            state       <= DONE;
            ack         <= gnt;
            resp_err    <= 1'b1;
            timeout_err <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          ack      <= '0;
          resp_err <= 1'b0;
          gnt      <= '0;
          busy     <= 1'b0;
          last_ptr <= gnt_idx;
        end
        default: begin
          state     <= IDLE;
          gnt       <= '0;
          ack       <= '0;
          resp_err  <= 1'b0;
          eng_start <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt         = gnt;
  assign bus.ack         = ack;
  assign bus.resp_err    = resp_err;
  assign bus.eng_start   = eng_start;
  assign bus.busy        = busy;
  assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_fsm_job_arbiter.sv
// Scoreboard bench: transaction-level reference predicts grants/acks; a monitor compares.
module tb_fsm_job_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fsm_job_arbiter_if #(.NUM_REQ(N)) bus ();

  fsm_job_arbiter #(
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {int cyc; int idx;} gexp_t;
  typedef struct {int cyc; int idx; bit err;} aexp_t;

  gexp_t grantq[$];
  aexp_t ackq[$];

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  logic [N-1:0] rq;
  bit svc[N];
  int svc_ack[N];
  int next_free, cur_grant, cur_ack, cur_idx, done_at, last;
  bit cur_err, te_exp, busy_exp, clr_prev, clr_force;
  logic [N-1:0] gnt_exp;
  int raise_pct, drop_pct, clr_pct, spur_pct, lat_ovr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 0;
    if (r == 1) return 1;
    if (r == 2) return TO;
    if (r < 7) return 2;
    return $urandom_range(1, TO);
  endfunction

  // One clock cycle of the reference: requesters, engine, and the arbitration decision.
  task automatic step();
    int w;
    int d;
    bit idle;
    bit done;
    bit clr;
    @(posedge clk);
    cyc++;
    #1;
    if (cyc == cur_ack && cur_err) te_exp = 1'b1;
    else if (clr_prev) te_exp = 1'b0;
    busy_exp = (cyc >= cur_grant && cyc <= cur_ack);
    gnt_exp  = busy_exp ? N'(1 << cur_idx) : '0;
    for (int i = 0; i < N; i++) begin
      if (svc[i] && cyc == svc_ack[i] + 1) begin
        svc[i] = 1'b0;
        rq[i]  = 1'b0;
      end else if (!svc[i] && !rq[i] && $urandom_range(0, 99) < raise_pct) rq[i] = 1'b1;
      else if (svc[i] && cyc < svc_ack[i] && $urandom_range(0, 99) < drop_pct) rq[i] = 1'b0;
    end
    idle = (cyc >= next_free);
    if (cyc == done_at) done = 1'b1;
    else done = (idle || cyc == cur_grant || cyc == cur_ack) && ($urandom_range(0, 99) < spur_pct);
    clr = clr_force || ($urandom_range(0, 99) < clr_pct);
    clr_force = 1'b0;
    clr_prev  = clr;
    if (idle && rq != '0) begin
      w = -1;
      for (int k = 1; k <= N; k++) if (w < 0 && rq[(last + k) % N]) w = (last + k) % N;
      d = (lat_ovr >= 0) ? lat_ovr : pick_lat();
      cur_grant  = cyc + 1;
      cur_idx    = w;
      cur_err    = (d == 0);
      cur_ack    = cur_err ? cyc + TO + 2 : cyc + d + 2;
      done_at    = cur_err ? -1 : cyc + 1 + d;
      next_free  = cur_ack + 1;
      last       = w;
      svc[w]     = 1'b1;
      svc_ack[w] = cur_ack;
      grantq.push_back('{cur_grant, w});
      ackq.push_back('{cur_ack, w, cur_err});
    end
    bus.req      = rq;
    bus.eng_done = done;
    bus.err_clr  = clr;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && !(rq == '0 && cyc >= next_free); k++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_gnt", bus.gnt, 0);
    check("rst_ack", bus.ack, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_eng_start", bus.eng_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    grantq.delete();
    ackq.delete();
    rq = '0;
    for (int i = 0; i < N; i++) svc[i] = 1'b0;
    last = N - 1;
    next_free = 0;
    cur_grant = -10;
    cur_ack = -10;
    cur_idx = 0;
    cur_err = 1'b0;
    done_at = -1;
    te_exp = 1'b0;
    busy_exp = 1'b0;
    gnt_exp = '0;
    clr_prev = 1'b0;
    clr_force = 1'b0;
    bus.req = '0;
    bus.eng_done = 1'b0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: per-cycle level checks plus scoreboard pops on eng_start / ack.
  initial begin
    gexp_t g;
    aexp_t a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("gnt", bus.gnt, gnt_exp);
        check("busy", bus.busy, busy_exp);
        check("timeout_err", bus.timeout_err, te_exp);
        if (bus.eng_start) begin
          if (grantq.size() > 0 && grantq[0].cyc == cyc) begin
            g = grantq.pop_front();
            check("start_gnt", bus.gnt, 1 << g.idx);
          end else check("start_unexpected", bus.eng_start, 0);
        end else if (grantq.size() > 0 && grantq[0].cyc == cyc) begin
          g = grantq.pop_front();
          check("start_missing", bus.eng_start, 1);
        end
        if (bus.ack != '0) begin
          if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
            a = ackq.pop_front();
            check("ack_idx", bus.ack, 1 << a.idx);
            check("resp_err", bus.resp_err, a.err);
          end else check("ack_unexpected", bus.ack, 0);
        end else begin
          check("resp_err_idle", bus.resp_err, 0);
          if (ackq.size() > 0 && ackq[0].cyc == cyc) begin
            a = ackq.pop_front();
            check("ack_missing", bus.ack, 1 << a.idx);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    raise_pct = 0; drop_pct = 0; clr_pct = 0; spur_pct = 0; lat_ovr = 2;
    #1;
    do_reset();

    rq = 4'b0100; run(8);
    spur_pct = 100; run(4); spur_pct = 0;

    rq = 4'b0010; run(2); rq[1] = 1'b0; run(6);

    lat_ovr = 0; rq = 4'b0001; run(21);
    clr_force = 1'b1; run(3);
    lat_ovr = 2; rq = 4'b1000; run(6);

    lat_ovr = 0; rq = 4'b0010; step();
    while (cyc < cur_ack - 2) step();
    clr_force = 1'b1; run(4);
    clr_force = 1'b1; run(2);

    lat_ovr = TO; rq = 4'b0100; run(20);

    lat_ovr = 2; raise_pct = 100; rq = 4'b1111; run(26);
    raise_pct = 0; drain();

    rq = 4'b0100; run(3);
    #2;
    do_reset();
    rq = 4'b1001; run(6); drain();

    lat_ovr = -1; raise_pct = 20; drop_pct = 10; clr_pct = 8; spur_pct = 30;
    run(2500);
    raise_pct = 0; drop_pct = 0; clr_pct = 0; spur_pct = 0;
    drain();
    run(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fsm_job_arbiter.md
# fsm_job_arbiter

Round-robin controller that shares one start/done processing engine among `NUM_REQ` requesters. It grants one requester at a time, issues a single-cycle `eng_start` pulse, waits for the engine's `done`, and returns a completion pulse to the granted requester. A watchdog counter aborts a transaction whose `done` never arrives and flags the fault. It sits between the requester ports and the engine's `start`/`done` pins; the engine itself is unchanged.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `TIMEOUT`, 16: maximum cycles spent in WAIT before abort, ≥ 4.
- `CNT_W`, `$clog2(TIMEOUT)`: watchdog counter width (localparam, not overridable).

- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in `NUM_REQ`: per-requester request level; held until `ack`.
- `gnt` out `NUM_REQ`: one-hot grant; at most one bit set.
- `ack` out `NUM_REQ`: one-cycle completion pulse to the granted requester.
- `resp_err` out 1: qualifies `ack`; 1 means the transaction timed out.
- `eng_start` out 1: one-cycle start pulse to the engine.
- `eng_done` in 1: engine done level.
- `busy` out 1: high in every state except IDLE.
- `timeout_err` out 1: sticky fault flag.
- `err_clr` in 1: synchronous clear for `timeout_err`.

## Operation
- The FSM uses one-hot encoding and has four states: IDLE, ISSUE, WAIT and DONE.
- **IDLE:** if any `req` bit is set, the arbiter picks the winner round-robin, starting the search at `last_ptr+1` and wrapping modulo `NUM_REQ`. It registers the winner into `gnt` and moves to ISSUE. With no request it stays in IDLE.
- **ISSUE:** `eng_start`=1 for exactly this cycle. Always moves to WAIT. The watchdog counter clears to 0.
- **WAIT:** the counter increments each cycle.
  - If `eng_done`=1, move to DONE with `resp_err`=0.
  - Otherwise, if the counter equals `TIMEOUT-1`, move to DONE with `resp_err`=1 and set `timeout_err`.
  - If `eng_done` arrives in the same cycle as the limit, `done` wins: no error.
- **DONE:** `ack[g]`=1 for one cycle, where `g` is the granted index. `resp_err` is valid in this cycle only and is 0 otherwise. `last_ptr` is set to `g`. `gnt` clears at the end of the cycle. Always moves to IDLE.
- `req` is sampled only in IDLE.
  - A `req` that drops during ISSUE/WAIT/DONE has no effect; the transaction completes and still acks.
  - The requester must drop `req` by the cycle after `ack`. A `req` still high in IDLE is treated as a new request.
- `eng_done` is ignored outside WAIT.
- `timeout_err` is set only in the WAIT→DONE timeout transition.
  - `err_clr`=1 clears it on the next edge.
  - If a set and a clear happen in the same cycle, the set wins.
- **Reset values:** `gnt`, `ack`, `resp_err`, `eng_start`, `busy` and `timeout_err` are all 0. State is IDLE, the counter is 0, and `last_ptr`=`NUM_REQ-1`, so `req[0]` has first priority.
- **Reset mid-transaction:** the arbiter returns to IDLE immediately, with no `ack`. The engine is reset by its own reset.

## Timing
- Requests are registered; nothing is combinational from `req` to `gnt`.
- All outputs are registered or decoded from one-hot state bits only.
- **Nominal engine, `req` rising in IDLE at cycle 0:**
  - cycle 1: `gnt` and `eng_start`.
  - cycle 2: WAIT.
  - cycle 3: engine in PROCESS (`eng_done`=1).
  - cycle 4: `ack`.
  - cycle 5: IDLE, with the next grant at the earliest in cycle 6.
- **Timeout:** `ack` with `resp_err`=1 arrives at cycle `TIMEOUT+2` after the request, i.e. cycle 18 with the default.
- Back-to-back throughput is one transaction per 5 cycles with the nominal engine.

## Structure
- The `fsm_arb_pkg` package holds:
  - the one-hot `arb_state_t` typedef (IDLE=4'b0001, ISSUE=4'b0010, WAIT=4'b0100, DONE=4'b1000);
  - the `ARB_NUM_REQ_MAX`=16 constant.
- Sub-module `rr_picker`: purely combinational. Takes `req` and `last_ptr`; produces a one-hot `pick` and `pick_idx`. It is instantiated once.
- The top level contains the FSM, the watchdog counter, the `last_ptr` register and the `timeout_err` flag.

## Test plan
- **Single request:** `req`=4'b0100 at cycle 0 → `gnt`=4'b0100 and `eng_start` at cycle 1, `ack`=4'b0100 with `resp_err`=0 at cycle 4, `busy` low at cycle 5.
- **All requesting:** `req`=4'b1111 held throughout, each requester dropping its bit after its `ack` and re-raising it → grant order 0,1,2,3,0. Never two `gnt` bits set at once.
- **Timeout:** `eng_done` tied 0 → `ack` with `resp_err`=1 at cycle 18. `timeout_err` stays 1 until `err_clr`, clears on the next edge. A next transaction succeeds.
- **Race at the limit:** `eng_done` in the same cycle the counter reaches 15 → `resp_err`=0 and `timeout_err` stays 0.
- **Reset mid-WAIT:** assert `rst` at cycle 2 → all outputs 0 at once, no `ack`. After release, `req`=4'b1000|4'b0001 → `req[0]` is granted first.
- **Spurious/dropped signals:** `eng_done` pulsed in IDLE → no state change. `req` dropped during WAIT → `ack` is still issued at cycle 4.
